// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: FSM states, opcode map,
// ALU operation codes and the control-signal bundle the sequencer drives.
package cpu_pkg;

   // Sequencer states: FETCH, DECODE, then ADDR_HI/EXEC for addressed ops.
   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      ADDR_HI = 3'd2,
      EXEC    = 3'd3,
      HALT    = 3'd4
   } state_t;

   // Instruction opcodes (all legal opcodes have a zero upper nibble).
   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDAC = 8'h01;
   localparam logic [7:0] OP_STAC = 8'h02;
   localparam logic [7:0] OP_MVAC = 8'h03;
   localparam logic [7:0] OP_MOVR = 8'h04;
   localparam logic [7:0] OP_JUMP = 8'h05;
   localparam logic [7:0] OP_JMPZ = 8'h06;
   localparam logic [7:0] OP_JPNZ = 8'h07;
   localparam logic [7:0] OP_ADD  = 8'h08;
   localparam logic [7:0] OP_SUB  = 8'h09;
   localparam logic [7:0] OP_INAC = 8'h0A;
   localparam logic [7:0] OP_CLAC = 8'h0B;
   localparam logic [7:0] OP_AND  = 8'h0C;
   localparam logic [7:0] OP_OR   = 8'h0D;
   localparam logic [7:0] OP_XOR  = 8'h0E;
   localparam logic [7:0] OP_NOT  = 8'h0F;

   // ALU operation codes, shared with the datapath ALU.
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_INAC = 3'b010;
   localparam logic [2:0] ALU_CLAC = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_OR   = 3'b101;
   localparam logic [2:0] ALU_XOR  = 3'b110;
   localparam logic [2:0] ALU_NOT  = 3'b111;

   // Every control line the sequencer presents to the datapath.
   typedef struct packed {
      logic       we_ac;
      logic       we_r;
      logic       we_mem;
      logic       pc_en;
      logic       ir_en;
      logic       msb_en;
      logic       lsb_en;
      logic       z_en;
      logic       sel_pc;
      logic       sel_addr;
      logic       sel_alu_to_ac;
      logic       sel_mem_or_r;
      logic       sel_zero;
      logic [2:0] alu_sel;
      logic       instr_done;
   } ctrl_t;

   // Quiescent bundle: no enables, all selects at their zero setting.
   localparam ctrl_t CTRL_IDLE = ctrl_t'(17'h0_0000);

   // ALU opcodes 0x08..0x0F map linearly onto ALU codes 0..7.
   function automatic logic [2:0] alu_code(input logic [3:0] op_lo);
      return op_lo[2:0];
   endfunction

   // Opcodes that carry a two-byte operand address.
   function automatic logic is_addressed(input logic [3:0] op_lo);
      logic hit;
      case (op_lo)
         4'h1, 4'h2, 4'h5, 4'h6, 4'h7: hit = 1'b1;
         default:                      hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control decode: maps (state, opcode, Z flag) onto the
// datapath control bundle and the sequencer's next state.
module control_decode
   import cpu_pkg::*;
#(
   parameter int OPW = 8
) (
   input  state_t         state,
   input  logic [OPW-1:0] opcode,
   input  logic           zeroFlag,
   output ctrl_t          ctrl,
   output state_t         next_state
);

   logic       op_legal_s;
   logic [3:0] op_lo_s;

   assign op_legal_s = (opcode[OPW-1:4] == {(OPW-4){1'b0}});
   assign op_lo_s    = opcode[3:0];

   // Per-state control outputs and next-state selection.
   always_comb begin
      ctrl       = CTRL_IDLE;
      next_state = FETCH;
      case (state)
         FETCH: begin
            // IR captures the opcode byte while PC steps past it.
            ctrl.sel_addr = 1'b0;
            ctrl.ir_en    = 1'b1;
            ctrl.pc_en    = 1'b1;
            ctrl.sel_pc   = 1'b0;
            next_state    = DECODE;
         end
         DECODE: begin
            if (!op_legal_s) begin
               next_state = HALT;
            end else if (is_addressed(op_lo_s)) begin
               // Low address byte sits right after the opcode.
               ctrl.sel_addr = 1'b0;
               ctrl.lsb_en   = 1'b1;
               ctrl.pc_en    = 1'b1;
               next_state    = ADDR_HI;
            end else begin
               next_state = FETCH;
               case (op_lo_s)
                  OP_NOP[3:0]: begin
                     ctrl.instr_done = 1'b1;
                  end
                  OP_MVAC[3:0]: begin
                     ctrl.we_r       = 1'b1;
                     ctrl.instr_done = 1'b1;
                  end
                  OP_MOVR[3:0]: begin
                     ctrl.we_ac         = 1'b1;
                     ctrl.sel_alu_to_ac = 1'b1;
                     ctrl.sel_mem_or_r  = 1'b1;
                     ctrl.z_en          = 1'b1;
                     ctrl.sel_zero      = 1'b1;
                     ctrl.instr_done    = 1'b1;
                  end
                  OP_ADD[3:0], OP_SUB[3:0], OP_INAC[3:0], OP_CLAC[3:0],
                  OP_AND[3:0], OP_OR[3:0],  OP_XOR[3:0],  OP_NOT[3:0]: begin
                     ctrl.alu_sel       = alu_code(op_lo_s);
                     ctrl.we_ac         = 1'b1;
                     ctrl.sel_alu_to_ac = 1'b0;
                     ctrl.z_en          = 1'b1;
                     ctrl.sel_zero      = 1'b0;
                     ctrl.instr_done    = 1'b1;
                  end
                  default: begin
                     // Addressed opcodes are handled above; nothing reaches here.
                     next_state = HALT;
                  end
               endcase
            end
         end
         ADDR_HI: begin
            // High address byte follows; PC then points past the operand.
            ctrl.sel_addr = 1'b0;
            ctrl.msb_en   = 1'b1;
            ctrl.pc_en    = 1'b1;
            next_state    = EXEC;
         end
         EXEC: begin
            ctrl.sel_addr   = 1'b1;
            ctrl.instr_done = 1'b1;
            next_state      = FETCH;
            case (op_lo_s)
               OP_LDAC[3:0]: begin
                  ctrl.we_ac         = 1'b1;
                  ctrl.sel_alu_to_ac = 1'b1;
                  ctrl.sel_mem_or_r  = 1'b0;
                  ctrl.z_en          = 1'b1;
                  ctrl.sel_zero      = 1'b1;
               end
               OP_STAC[3:0]: begin
                  ctrl.we_mem = 1'b1;
               end
               OP_JUMP[3:0]: begin
                  ctrl.pc_en  = 1'b1;
                  ctrl.sel_pc = 1'b1;
               end
               OP_JMPZ[3:0]: begin
                  // Not taken leaves PC past both address bytes.
                  ctrl.pc_en  = zeroFlag;
                  ctrl.sel_pc = 1'b1;
               end
               OP_JPNZ[3:0]: begin
                  ctrl.pc_en  = ~zeroFlag;
                  ctrl.sel_pc = 1'b1;
               end
               default: begin
                  ctrl.sel_pc = 1'b0;
               end
            endcase
         end
         HALT: begin
            next_state = HALT;
         end
         default: begin
            next_state = FETCH;
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the accumulator datapath: holds the FSM state,
// forces all control lines quiet while reset is high, flags illegal opcodes.
module control_unit
   import cpu_pkg::*;
#(
   parameter int OPW = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic           zeroFlag,
   output logic           writeEnableAC,
   output logic           writeEnableR,
   output logic           writeEnableMem,
   output logic           PCEnable,
   output logic           instructionRegisterEnable,
   output logic           MSBaddressEnable,
   output logic           LSBaddressEnable,
   output logic           zeroEnable,
   output logic           muxSelectPC,
   output logic           muxSelectAddress,
   output logic           muxSelectALUtoAC,
   output logic           muxSelectMEM_or_R_toAC,
   output logic           muxSelectZero,
   output logic [2:0]     ALUselectLine,
   output logic           instrDone,
   output logic           halted
);

   state_t state_r;
   state_t next_state_s;
   logic   halted_r;
   ctrl_t  ctrl_s;
   ctrl_t  ctrl_out_s;

   control_decode #(
      .OPW (OPW)
   ) u_decode (
      .state      (state_r),
      .opcode     (opcode),
      .zeroFlag   (zeroFlag),
      .ctrl       (ctrl_s),
      .next_state (next_state_s)
   );

   // State register and sticky halt flag; reset returns to FETCH at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= FETCH;
         halted_r <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         halted_r <= (next_state_s == HALT);
      end
   end

   // Reset overrides decode so no write can complete while reset is high.
   always_comb begin
      if (reset) begin
         ctrl_out_s = CTRL_IDLE;
      end else begin
         ctrl_out_s = ctrl_s;
      end
   end

   assign writeEnableAC             = ctrl_out_s.we_ac;
   assign writeEnableR              = ctrl_out_s.we_r;
   assign writeEnableMem            = ctrl_out_s.we_mem;
   assign PCEnable                  = ctrl_out_s.pc_en;
   assign instructionRegisterEnable = ctrl_out_s.ir_en;
   assign MSBaddressEnable          = ctrl_out_s.msb_en;
   assign LSBaddressEnable          = ctrl_out_s.lsb_en;
   assign zeroEnable                = ctrl_out_s.z_en;
   assign muxSelectPC               = ctrl_out_s.sel_pc;
   assign muxSelectAddress          = ctrl_out_s.sel_addr;
   assign muxSelectALUtoAC          = ctrl_out_s.sel_alu_to_ac;
   assign muxSelectMEM_or_R_toAC    = ctrl_out_s.sel_mem_or_r;
   assign muxSelectZero             = ctrl_out_s.sel_zero;
   assign ALUselectLine             = ctrl_out_s.alu_sel;
   assign instrDone                 = ctrl_out_s.instr_done;
   assign halted                    = halted_r;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes the expected control
// vector for every cycle, a negedge monitor pops and compares.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] opcode;
   logic       zeroFlag;
   logic       writeEnableAC, writeEnableR, writeEnableMem, PCEnable;
   logic       instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable;
   logic       zeroEnable, muxSelectPC, muxSelectAddress, muxSelectALUtoAC;
   logic       muxSelectMEM_or_R_toAC, muxSelectZero, instrDone, halted;
   logic [2:0] ALUselectLine;

   int checks    = 0;
   int failures  = 0;
   int exp_done  = 0;
   int got_done  = 0;

   logic [17:0] sb[$];
   string       nm[$];

   control_unit #(.OPW(8)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .opcode                    (opcode),
      .zeroFlag                  (zeroFlag),
      .writeEnableAC             (writeEnableAC),
      .writeEnableR              (writeEnableR),
      .writeEnableMem            (writeEnableMem),
      .PCEnable                  (PCEnable),
      .instructionRegisterEnable (instructionRegisterEnable),
      .MSBaddressEnable          (MSBaddressEnable),
      .LSBaddressEnable          (LSBaddressEnable),
      .zeroEnable                (zeroEnable),
      .muxSelectPC               (muxSelectPC),
      .muxSelectAddress          (muxSelectAddress),
      .muxSelectALUtoAC          (muxSelectALUtoAC),
      .muxSelectMEM_or_R_toAC    (muxSelectMEM_or_R_toAC),
      .muxSelectZero             (muxSelectZero),
      .ALUselectLine             (ALUselectLine),
      .instrDone                 (instrDone),
      .halted                    (halted)
   );

   always #5 clk = ~clk;

   // Instruction length in cycles; illegal opcodes stop after decode.
   function automatic int ilen(input logic [7:0] op);
      if (op > 8'h0F) return 2;
      if (op == 8'h01 || op == 8'h02 || (op >= 8'h05 && op <= 8'h07)) return 4;
      return 2;
   endfunction

   // Reference: expected control vector for cycle k of instruction op.
   // Layout: weAC weR weMem pcEn irEn msbEn lsbEn zEn selPC selAddr
   //         selALUtoAC selMemR selZero alu[2:0] done halted
   function automatic logic [17:0] model(input logic [7:0] op, input logic z,
                                         input int k, input bit in_halt,
                                         input bit in_reset);
      logic we_ac, we_r, we_mem, pc_en, ir_en, msb_en, lsb_en, z_en;
      logic s_pc, s_addr, s_alu, s_mr, s_z, done, hlt;
      logic [2:0] alu;
      {we_ac, we_r, we_mem, pc_en, ir_en, msb_en, lsb_en, z_en} = 8'h00;
      {s_pc, s_addr, s_alu, s_mr, s_z, done, hlt} = 7'h00;
      alu = 3'b000;
      if (in_reset) begin
         hlt = 1'b0;
      end else if (in_halt) begin
         hlt = 1'b1;
      end else if (k == 0) begin
         ir_en = 1'b1; pc_en = 1'b1;
      end else if (k == 1) begin
         if (op > 8'h0F) begin
            done = 1'b0;
         end else if (op >= 8'h08) begin
            alu = 3'(op - 8'h08); we_ac = 1'b1; z_en = 1'b1; done = 1'b1;
         end else if (op == 8'h00) begin
            done = 1'b1;
         end else if (op == 8'h03) begin
            we_r = 1'b1; done = 1'b1;
         end else if (op == 8'h04) begin
            we_ac = 1'b1; s_alu = 1'b1; s_mr = 1'b1; z_en = 1'b1; s_z = 1'b1; done = 1'b1;
         end else begin
            lsb_en = 1'b1; pc_en = 1'b1;
         end
      end else if (k == 2) begin
         msb_en = 1'b1; pc_en = 1'b1;
      end else begin
         s_addr = 1'b1; done = 1'b1;
         if (op == 8'h01) begin
            we_ac = 1'b1; s_alu = 1'b1; z_en = 1'b1; s_z = 1'b1;
         end else if (op == 8'h02) begin
            we_mem = 1'b1;
         end else begin
            s_pc  = 1'b1;
            pc_en = (op == 8'h05) ? 1'b1 : (op == 8'h06) ? z : ~z;
         end
      end
      return {we_ac, we_r, we_mem, pc_en, ir_en, msb_en, lsb_en, z_en,
              s_pc, s_addr, s_alu, s_mr, s_z, alu, done, hlt};
   endfunction

   // One stimulus cycle: drive inputs after the edge and queue the expectation.
   task automatic drive(input logic r, input logic [7:0] op, input int zf,
                        input int k, input bit hlt, input string n);
      @(posedge clk);
      #1;
      reset    = r;
      opcode   = op;
      zeroFlag = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      sb.push_back(model(op, zeroFlag, k, hlt, r));
      nm.push_back(n);
   endtask

   task automatic run_instr(input logic [7:0] op, input int zf, input string n);
      int len;
      len = ilen(op);
      for (int k = 0; k < len; k++) drive(1'b0, op, zf, k, 1'b0, n);
      if (op <= 8'h0F) exp_done++;
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 8'($urandom), -1, 0, 1'b0, "reset");
   endtask

   task automatic halt_cycles(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), -1, 0, 1'b1, "halt");
   endtask

   // Monitor: compare every presented cycle against the scoreboard head.
   initial begin
      logic [17:0] act, e;
      string       n;
      forever begin
         @(negedge clk);
         act = {writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
                instructionRegisterEnable, MSBaddressEnable, LSBaddressEnable,
                zeroEnable, muxSelectPC, muxSelectAddress, muxSelectALUtoAC,
                muxSelectMEM_or_R_toAC, muxSelectZero, ALUselectLine,
                instrDone, halted};
         if (instrDone === 1'b1) got_done++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n = nm.pop_front();
            checks++;
            if (act !== e) begin
               failures++;
               $display("FAIL %s got=%05h expected=%05h", n, act, e);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      opcode   = 8'h00;
      zeroFlag = 1'b0;
      reset_cycles(3);
      run_instr(8'h00, -1, "nop");
      run_instr(8'h08, -1, "add");
      run_instr(8'h01, -1, "ldac");
      run_instr(8'h06, 1, "jmpz_taken");
      run_instr(8'h06, 0, "jmpz_not_taken");
      run_instr(8'h07, 0, "jpnz_taken");
      run_instr(8'h04, -1, "movr");
      run_instr(8'h03, -1, "mvac");
      // STAC aborted by reset during the high-address cycle.
      drive(1'b0, 8'h02, -1, 0, 1'b0, "stac_abort");
      drive(1'b0, 8'h02, -1, 1, 1'b0, "stac_abort");
      drive(1'b1, 8'h02, -1, 2, 1'b0, "stac_abort_rst");
      run_instr(8'h00, -1, "after_abort");
      for (int i = 0; i < 300; i++) begin
         run_instr(8'($urandom_range(0, 15)), -1, "random");
      end
      run_instr(8'h3C, -1, "illegal");
      halt_cycles(20);
      reset_cycles(1);
      run_instr(8'h0F, -1, "not_after_halt");
      run_instr(8'h05, -1, "jump_after_halt");
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      checks++;
      if (got_done != exp_done) begin
         failures++;
         $display("FAIL instr_done_count got=%0d expected=%0d", got_done, exp_done);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
